// File: rtl/dht11_pkg.sv
// DHT11 responder shared definitions: FSM states, frame size, default timing
// and fault-injection encodings (fault injection is built only when
// DHT11_FAULT_INJECT_EN is defined).
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST_START,
    RESP_DELAY,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  localparam int unsigned FRAME_BITS = 40;

  localparam int unsigned DEF_CLKS_PER_US   = 50;
  localparam int unsigned DEF_START_MIN_US  = 18000;
  localparam int unsigned DEF_RESP_DELAY_US = 30;
  localparam int unsigned DEF_ACK_LOW_US    = 80;
  localparam int unsigned DEF_ACK_HIGH_US   = 80;
  localparam int unsigned DEF_BIT_LOW_US    = 50;
  localparam int unsigned DEF_BIT0_HIGH_US  = 27;
  localparam int unsigned DEF_BIT1_HIGH_US  = 70;

  localparam logic [15:0] US_CNT_MAX = 16'hFFFF;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_INV_CSUM = 2'b01;
  localparam logic [1:0] FAULT_NO_ACK   = 2'b10;
  localparam logic [1:0] FAULT_TRUNC    = 2'b11;

  // After bits 39..24 (16 data bits) a truncated frame jumps to the end marker.
  localparam logic [5:0] TRUNC_BIT_INDEX = 6'd24;

  // Sum of the four data bytes, modulo 256.
  function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Restartable modulo-CLKS_PER_US counter; o_tick is high for one cycle once
// per microsecond, and a restart realigns the microsecond grid to the next cycle.
module dht11_us_tick
  import dht11_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_US - 1);

  logic [W-1:0] r_cnt;

  // Free-running modulo counter, cleared on restart.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          r_cnt <= '0;
    else if (i_restart || r_cnt == LAST) r_cnt <= '0;
    else                                r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator on an open-drain line: accepts a host start pulse,
// then sends ack and a 40-bit {hi, hd, ti, td, checksum} frame MSB first.
// Optional macro DHT11_FAULT_INJECT_EN adds the fault_mode input.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLKS_PER_US   = DEF_CLKS_PER_US,
  parameter int unsigned START_MIN_US  = DEF_START_MIN_US,
  parameter int unsigned RESP_DELAY_US = DEF_RESP_DELAY_US,
  parameter int unsigned ACK_LOW_US    = DEF_ACK_LOW_US,
  parameter int unsigned ACK_HIGH_US   = DEF_ACK_HIGH_US,
  parameter int unsigned BIT_LOW_US    = DEF_BIT_LOW_US,
  parameter int unsigned BIT0_HIGH_US  = DEF_BIT0_HIGH_US,
  parameter int unsigned BIT1_HIGH_US  = DEF_BIT1_HIGH_US
) (
  input  logic       clock,
  input  logic       reset,
  inout  logic       transmission_line,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temperature_int,
  input  logic [7:0] temperature_dec,
`ifdef DHT11_FAULT_INJECT_EN
  input  logic [1:0] fault_mode,
`endif
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] start_count
);

  localparam logic [15:0] L_START_MIN = 16'(START_MIN_US);
  localparam logic [15:0] L_RESP      = 16'(RESP_DELAY_US - 1);
  localparam logic [15:0] L_ACK_LOW   = 16'(ACK_LOW_US - 1);
  localparam logic [15:0] L_ACK_HIGH  = 16'(ACK_HIGH_US - 1);
  localparam logic [15:0] L_BIT_LOW   = 16'(BIT_LOW_US - 1);
  localparam logic [15:0] L_BIT0      = 16'(BIT0_HIGH_US - 1);
  localparam logic [15:0] L_BIT1      = 16'(BIT1_HIGH_US - 1);

  state_t                  r_state, w_next;
  logic                    r_sync1, r_sync2, r_prev;
  logic                    w_fall, w_rise, w_tick, w_restart;
  logic [15:0]             r_us, w_last;
  logic                    w_phase_end, w_accept, w_bit;
  logic [5:0]              r_bit_idx;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [1:0]              r_fault, w_fault_in;
  logic [7:0]              r_start_count;
  logic                    r_drive_low, r_busy, r_frame_done;
  logic                    w_drive_next, w_busy_next, w_done_next;

`ifdef DHT11_FAULT_INJECT_EN
  assign w_fault_in = fault_mode;
`else
  assign w_fault_in = FAULT_NONE;
`endif

  assign w_fall      = r_prev & ~r_sync2;
  assign w_rise      = ~r_prev & r_sync2;
  assign w_restart   = (w_next != r_state);
  assign w_bit       = r_frame[r_bit_idx];
  assign w_phase_end = w_tick && (r_us == w_last);
  assign w_accept    = (r_state == HOST_START) && w_rise && (r_us >= L_START_MIN);

  dht11_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Last microsecond index of the current timed phase.
  always_comb begin
    w_last = L_BIT_LOW;
    unique case (r_state)
      RESP_DELAY: w_last = L_RESP;
      ACK_LOW:    w_last = L_ACK_LOW;
      ACK_HIGH:   w_last = L_ACK_HIGH;
      BIT_HIGH:   w_last = w_bit ? L_BIT1 : L_BIT0;
      default:    w_last = L_BIT_LOW;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; only IDLE and HOST_START look at the line.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (w_fall) w_next = HOST_START;
      HOST_START: if (w_rise) w_next = w_accept ? RESP_DELAY : IDLE;
      RESP_DELAY: if (w_phase_end) w_next = ACK_LOW;
      ACK_LOW:    if (w_phase_end) w_next = ACK_HIGH;
      ACK_HIGH:   if (w_phase_end) w_next = (r_fault == FAULT_NO_ACK) ? IDLE : BIT_LOW;
      BIT_LOW:    if (w_phase_end) w_next = BIT_HIGH;
      BIT_HIGH:
        if (w_phase_end)
          w_next = ((r_bit_idx == '0) ||
                    (r_fault == FAULT_TRUNC && r_bit_idx == TRUNC_BIT_INDEX)) ? END_LOW : BIT_LOW;
      END_LOW:    if (w_phase_end) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs align with it.
  always_comb begin
    w_drive_next = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    unique case (w_next)
      ACK_LOW:            w_drive_next = (r_fault != FAULT_NO_ACK);
      BIT_LOW, END_LOW:   w_drive_next = 1'b1;
      default:            w_drive_next = 1'b0;
    endcase
    w_busy_next = (w_next != IDLE) && (w_next != HOST_START);
    w_done_next = (r_state == END_LOW) && (w_next == IDLE);
  end

  // Registered outputs; reset releases the line without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drive_low  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_drive_low  <= w_drive_next;
      r_busy       <= w_busy_next;
      r_frame_done <= w_done_next;
    end
  end

  // Line synchronizer, phase microsecond counter, bit index and frame snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_prev        <= 1'b0;
      r_us          <= '0;
      r_bit_idx     <= '0;
      r_frame       <= '0;
      r_fault       <= FAULT_NONE;
      r_start_count <= '0;
    end else begin
      r_sync1 <= transmission_line;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (w_restart)                       r_us <= '0;
      else if (w_tick && r_us != US_CNT_MAX) r_us <= r_us + 1'b1;

      if (r_state == ACK_HIGH && w_next == BIT_LOW)
        r_bit_idx <= 6'(FRAME_BITS - 1);
      else if (r_state == BIT_HIGH && w_next == BIT_LOW)
        r_bit_idx <= r_bit_idx - 1'b1;

      if (w_accept) begin
        r_frame <= {humidity_int, humidity_dec, temperature_int, temperature_dec,
                    dht11_checksum(humidity_int, humidity_dec, temperature_int, temperature_dec)
                      ^ ((w_fault_in == FAULT_INV_CSUM) ? 8'hFF : 8'h00)};
        r_fault       <= w_fault_in;
        r_start_count <= r_start_count + 1'b1;
      end
    end
  end

  assign transmission_line = r_drive_low ? 1'b0 : 1'bz;
  assign busy              = r_busy;
  assign frame_done        = r_frame_done;
  assign start_count       = r_start_count;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed + randomized bench for dht11_responder. Line activity driven by the
// DUT is recorded as run lengths and compared with durations derived from the
// protocol timing and the expected frame bytes.
module tb_dht11_responder;

  localparam int unsigned C         = 2;     // clocks per microsecond
  localparam int unsigned START_MIN = 100;
  localparam int          N_RUNS    = 85;    // resp high, ack low/high, 40 x (low, high), end low, trailing high
  localparam int          BOUND     = 12000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] hi = '0, hd = '0, ti = '0, td = '0;
  logic [1:0] fault = 2'b00;
  logic       busy, frame_done;
  logic [7:0] start_count;
  wire        w_line;

  assign w_line = host_low ? 1'b0 : 1'bz;
  pullup (w_line);

  dht11_responder #(.CLKS_PER_US(C), .START_MIN_US(START_MIN)) dut (
    .clock             (clock),
    .reset             (reset),
    .transmission_line (w_line),
    .humidity_int      (hi),
    .humidity_dec      (hd),
    .temperature_int   (ti),
    .temperature_dec   (td),
`ifdef DHT11_FAULT_INJECT_EN
    .fault_mode        (fault),
`endif
    .busy              (busy),
    .frame_done        (frame_done),
    .start_count       (start_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic lvl; int len; } run_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  run_t runs[$];
  int   exp_len[$];
  logic rec = 1'b0;
  logic cur_lvl = 1'b1;
  int   cur_len = 0;
  int   done_cnt = 0;
  logic busy_seen = 1'b0;
  int   exp_starts = 0;

  // Run-length recorder of what the responder drives (host drive excluded).
  always @(negedge clock) begin
    logic lvl;
    lvl = (w_line === 1'b0 && !host_low) ? 1'b0 : 1'b1;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (rec) begin
      if (lvl == cur_lvl) cur_len++;
      else begin
        runs.push_back('{cur_lvl, cur_len});
        cur_lvl = lvl;
        cur_len = 1;
      end
    end
  end

  always @(posedge clock) if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input logic [1:0] f);
    int s;
    logic [7:0] cs;
    s  = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    cs = 8'(s);
    if (f == 2'b01) cs = ~cs;
    return {a, b, c, d, cs};
  endfunction

  task automatic start_rec();
    runs.delete();
    cur_lvl   = 1'b1;
    cur_len   = 0;
    busy_seen = 1'b0;
    rec       = 1'b1;
  endtask

  task automatic stop_rec();
    rec = 1'b0;
    runs.push_back('{cur_lvl, cur_len});
  endtask

  // Host holds the line low for 'us' microseconds, then releases and recording begins.
  task automatic host_pulse(input int us);
    @(negedge clock); #1 host_low = 1'b1;
    repeat (us * C) @(negedge clock);
    #1 host_low = 1'b0;
    start_rec();
  endtask

  task automatic wait_runs(input string tag, input int n, input logic lvl);
    int t = 0;
    while (!(runs.size() == n && cur_lvl == lvl) && t < BOUND) begin
      @(negedge clock); t++;
    end
    chk({tag, " reached"}, 64'(t < BOUND), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int t  = 0;
    while (done_cnt == d0 && t < BOUND) begin
      @(negedge clock); t++;
    end
    repeat (20) @(negedge clock);
    #1 stop_rec();
    chk({tag, " frame_done pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, " busy after frame"}, 64'(busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [39:0] f);
    logic [39:0] dec;
    exp_len.delete();
    exp_len.push_back(80 * C);
    exp_len.push_back(80 * C);
    for (int b = 39; b >= 0; b--) begin
      exp_len.push_back(50 * C);
      exp_len.push_back((f[b] ? 70 : 27) * C);
    end
    exp_len.push_back(50 * C);
    chk({tag, " run count"}, 64'(runs.size()), 64'(N_RUNS));
    if (runs.size() == N_RUNS) begin
      chk({tag, " resp delay"}, 64'(runs[0].len >= 30 * C && runs[0].len <= 30 * C + 4), 64'd1);
      chk({tag, " ack low level"}, 64'(runs[1].lvl), 64'd0);
      for (int i = 1; i <= 83; i++)
        chk($sformatf("%s run%0d len", tag, i), 64'(runs[i].len), 64'(exp_len[i-1]));
      for (int b = 0; b < 40; b++)
        dec[39-b] = (runs[4 + 2*b].len > (27 + 70) * C / 2);
      chk({tag, " decoded frame"}, 64'(dec), 64'(f));
    end
  endtask

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    hi = a; hd = b; ti = c; td = d;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock); #3 reset = 1'b1;
    #1;
    chk({tag, " line released"}, 64'(w_line), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, " start_count"}, 64'(start_count), 64'd0);
    rec = 1'b0;
    exp_starts = 0;
    @(negedge clock); #1 reset = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    logic [39:0] f;
    int us;

    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    chk("reset start_count", 64'(start_count), 64'd0);
    chk("reset line", 64'(w_line), 64'd1);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    repeat (10) @(negedge clock);

    // T1: nominal frame
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    f = model_frame(hi, hd, ti, td, 2'b00);
    host_pulse(120);
    exp_starts++;
    repeat (100) @(negedge clock);
    chk("t1 busy in frame", 64'(busy), 64'd1);
    wait_done("t1");
    check_frame("t1", f);
    chk("t1 start_count", 64'(start_count), 64'(exp_starts));

    // T2: short host pulse is rejected
    host_pulse(60);
    repeat (400) @(negedge clock);
    #1 stop_rec();
    chk("t2 no drive", 64'(runs.size()), 64'd1);
    chk("t2 busy never", 64'(busy_seen), 64'd0);
    chk("t2 start_count", 64'(start_count), 64'(exp_starts));

    // T3: all-ones bytes, checksum wraps
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    f = model_frame(hi, hd, ti, td, 2'b00);
    host_pulse(120);
    exp_starts++;
    wait_done("t3");
    check_frame("t3", f);
    chk("t3 start_count", 64'(start_count), 64'(exp_starts));

    // T4: reset during BIT_HIGH of bit index 20, then a clean frame
    set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    host_pulse(120);
    wait_runs("t4 bit20 high", 42, 1'b1);
    repeat (10) @(negedge clock);
    do_reset("t4 reset");
    set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    f = model_frame(hi, hd, ti, td, 2'b00);
    host_pulse(120);
    exp_starts++;
    wait_done("t4 after");
    check_frame("t4 after", f);
    chk("t4 start_count", 64'(start_count), 64'(exp_starts));

    // T5: host activity during ACK_HIGH is ignored; next start accepted
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
    f = model_frame(hi, hd, ti, td, 2'b00);
    host_pulse(120);
    exp_starts++;
    wait_runs("t5 ack high", 2, 1'b1);
    repeat (20) @(negedge clock);
    #1 host_low = 1'b1;
    repeat (40) @(negedge clock);
    #1 host_low = 1'b0;
    wait_done("t5");
    check_frame("t5", f);
    chk("t5 start_count", 64'(start_count), 64'(exp_starts));
    host_pulse(120);
    exp_starts++;
    wait_done("t5 second");
    check_frame("t5 second", f);
    chk("t5 second start_count", 64'(start_count), 64'(exp_starts));

    // Randomized: host pulse width either side of the threshold, bytes change mid-frame
    for (int k = 0; k < 3; k++) begin
      set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      f  = model_frame(hi, hd, ti, td, 2'b00);
      us = ($urandom_range(0, 1) == 1) ? int'($urandom_range(105, 180)) : int'($urandom_range(40, 95));
      host_pulse(us);
      if (us >= int'(START_MIN)) begin
        exp_starts++;
        repeat (500) @(negedge clock);
        set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        wait_done($sformatf("rnd%0d", k));
        check_frame($sformatf("rnd%0d", k), f);
      end else begin
        repeat (400) @(negedge clock);
        #1 stop_rec();
        chk($sformatf("rnd%0d rejected", k), 64'(runs.size()), 64'd1);
      end
      chk($sformatf("rnd%0d start_count", k), 64'(start_count), 64'(exp_starts));
    end

    // T4b: reset while the responder drives ACK_LOW releases the line at once
    host_pulse(120);
    wait_runs("t4b ack low", 1, 1'b0);
    repeat (20) @(negedge clock);
    do_reset("t4b reset");

`ifdef DHT11_FAULT_INJECT_EN
    // T6: inverted checksum
    fault = 2'b01;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    f = model_frame(hi, hd, ti, td, 2'b01);
    host_pulse(120);
    exp_starts++;
    wait_done("t6");
    check_frame("t6", f);
    // T7: suppressed ack returns to idle without a frame
    fault = 2'b10;
    us = done_cnt;
    host_pulse(120);
    exp_starts++;
    repeat (600) @(negedge clock);
    #1 stop_rec();
    chk("t7 no drive", 64'(runs.size()), 64'd1);
    chk("t7 no frame_done", 64'(done_cnt), 64'(us));
    chk("t7 busy", 64'(busy), 64'd0);
    chk("t7 start_count", 64'(start_count), 64'(exp_starts));
    fault = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
